// File: rtl/instruction_fetch_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module   : instruction_fetch_stage_pkg
// Purpose  : Shared widths, encodings and helpers for the fetch stage slice.
// Revision : 1.0 - initial release
// ============================================================================
package instruction_fetch_stage_pkg;

   localparam int unsigned          c_XLEN      = 32;
   localparam logic [c_XLEN-1:0]    c_NOP_INSTR = 32'h0000_0013;
   localparam logic [c_XLEN-1:0]    c_PC_STEP   = 32'd4;

   typedef enum logic [1:0] {
      ST_BOOT  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_HOLD  = 2'd3
   } fetch_state_e;

   typedef struct packed {
      logic [c_XLEN-1:0] instr;
      logic [c_XLEN-1:0] pc;
      logic [c_XLEN-1:0] pc_plus4;
      logic              valid;
   } ifid_t;

   function automatic logic [c_XLEN-1:0] align_word(input logic [c_XLEN-1:0] addr);
      return {addr[c_XLEN-1:2], 2'b00};
   endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_hold_buffer.sv
`default_nettype none
// ============================================================================
// Module   : fetch_hold_buffer
// Purpose  : One-entry store for a fetched word plus the squash flag that
//            marks the outstanding memory return as stale.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_hold_buffer
   import instruction_fetch_stage_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_load,
   input  logic [c_XLEN-1:0] i_word,
   input  logic              i_drop,
   input  logic              i_squash_set,
   input  logic              i_squash_clr,
   output logic [c_XLEN-1:0] o_word,
   output logic              o_squash
);

   logic [c_XLEN-1:0] r_word;
   logic              r_squash;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_word <= '0;
      end else if (i_load) begin
         r_word <= i_word;
      end else if (i_drop) begin
         r_word <= '0;
      end
   end

   // Clearing wins: the stale return is consumed in the same cycle it lands.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_squash <= 1'b0;
      end else if (i_squash_clr) begin
         r_squash <= 1'b0;
      end else if (i_squash_set) begin
         r_squash <= 1'b1;
      end
   end

   assign o_word   = r_word;
   assign o_squash = r_squash;

endmodule
`default_nettype wire

// File: rtl/instruction_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module   : instruction_fetch_stage
// Purpose  : IF stage with IF/ID register; one-outstanding fetch from a
//            variable-latency instruction memory, bubbles when idle.
// Revision : 1.0 - initial release
// ============================================================================
module instruction_fetch_stage
   import instruction_fetch_stage_pkg::*;
#(
   parameter logic [c_XLEN-1:0] RESET_PC  = 32'h0000_0000,
   parameter logic [c_XLEN-1:0] NOP_INSTR = c_NOP_INSTR
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              StallF,
   input  logic              StallD,
   input  logic              FlushD,
   input  logic              PCSrcE,
   input  logic [c_XLEN-1:0] PCTargetE,
   output logic              imem_req,
   output logic [c_XLEN-1:0] imem_addr,
   input  logic [c_XLEN-1:0] imem_rdata,
   input  logic              imem_rvalid,
   output logic [c_XLEN-1:0] InstrD,
   output logic [c_XLEN-1:0] PCD,
   output logic [c_XLEN-1:0] PCPlus4D,
   output logic              ValidD
);

   localparam logic [c_XLEN-1:0] c_RESET_PC_ALIGNED = align_word(RESET_PC);
   localparam ifid_t c_IFID_BUBBLE = '{
      instr    : NOP_INSTR,
      pc       : '0,
      pc_plus4 : '0,
      valid    : 1'b0
   };

   fetch_state_e      r_state;
   fetch_state_e      w_state_next;
   logic [c_XLEN-1:0] r_pcf;
   logic [c_XLEN-1:0] w_pcf_next;
   logic [c_XLEN-1:0] w_pcf_plus4;
   ifid_t             r_ifid;

   logic              w_req;
   logic              w_del_ok;
   logic              w_deliver;
   logic [c_XLEN-1:0] w_deliver_word;
   logic              w_redirect;
   logic              w_buf_load;
   logic              w_buf_drop;
   logic              w_sq_set;
   logic              w_sq_clr;
   logic [c_XLEN-1:0] w_buf_word;
   logic              w_squash;

   assign w_del_ok    = !StallF && !StallD;
   assign w_pcf_plus4 = r_pcf + c_PC_STEP;
   assign w_redirect  = PCSrcE && (r_state != ST_BOOT);

   fetch_hold_buffer u_hold_buffer (
      .clk          (clk),
      .rst_n        (rst_n),
      .i_load       (w_buf_load),
      .i_word       (imem_rdata),
      .i_drop       (w_buf_drop),
      .i_squash_set (w_sq_set),
      .i_squash_clr (w_sq_clr),
      .o_word       (w_buf_word),
      .o_squash     (w_squash)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_BOOT;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Redirect and squash are resolved before delivery so a wrong-path word never reaches decode.
   always_comb begin
      w_state_next   = r_state;
      w_req          = 1'b0;
      w_deliver      = 1'b0;
      w_deliver_word = w_buf_word;
      w_buf_load     = 1'b0;
      w_buf_drop     = 1'b0;
      w_sq_set       = 1'b0;
      w_sq_clr       = 1'b0;
      case (r_state)
         ST_BOOT: begin
            w_state_next = ST_ISSUE;
         end
         ST_ISSUE: begin
            w_req = !StallF && !PCSrcE;
            if (w_req) begin
               w_state_next = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (imem_rvalid) begin
               if (w_squash || PCSrcE) begin
                  w_sq_clr     = 1'b1;
                  w_state_next = ST_ISSUE;
               end else if (w_del_ok) begin
                  w_deliver      = 1'b1;
                  w_deliver_word = imem_rdata;
                  w_state_next   = ST_ISSUE;
               end else begin
                  w_buf_load   = 1'b1;
                  w_state_next = ST_HOLD;
               end
            end else if (PCSrcE) begin
               w_sq_set = 1'b1;
            end
         end
         ST_HOLD: begin
            if (PCSrcE) begin
               w_buf_drop   = 1'b1;
               w_state_next = ST_ISSUE;
            end else if (w_del_ok) begin
               w_deliver    = 1'b1;
               w_state_next = ST_ISSUE;
            end
         end
         default: begin
            w_state_next = ST_BOOT;
         end
      endcase
   end

   always_comb begin
      w_pcf_next = r_pcf;
      if (w_redirect) begin
         w_pcf_next = align_word(PCTargetE);
      end else if (w_deliver) begin
         w_pcf_next = w_pcf_plus4;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pcf <= c_RESET_PC_ALIGNED;
      end else begin
         r_pcf <= w_pcf_next;
      end
   end

   // Flush beats stall so a squashed decode slot is cleared even while decode is frozen.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ifid <= c_IFID_BUBBLE;
      end else if (FlushD) begin
         r_ifid <= c_IFID_BUBBLE;
      end else if (StallD) begin
         r_ifid <= r_ifid;
      end else if (w_deliver) begin
         r_ifid.instr    <= w_deliver_word;
         r_ifid.pc       <= r_pcf;
         r_ifid.pc_plus4 <= w_pcf_plus4;
         r_ifid.valid    <= 1'b1;
      end else begin
         r_ifid <= c_IFID_BUBBLE;
      end
   end

   assign imem_req  = w_req;
   assign imem_addr = r_pcf;
   assign InstrD    = r_ifid.instr;
   assign PCD       = r_ifid.pc;
   assign PCPlus4D  = r_ifid.pc_plus4;
   assign ValidD    = r_ifid.valid;

endmodule
`default_nettype wire

// File: tb/tb_instruction_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_instruction_fetch_stage
// Purpose  : Directed scoreboard bench for instruction_fetch_stage.
// Revision : 1.0 - initial release
// ============================================================================
module tb_instruction_fetch_stage;

   typedef struct {
      logic [31:0] instr;
      logic [31:0] pc;
      logic [31:0] pc4;
   } exp_t;

   logic        clk;
   logic        rst_n;
   logic        StallF;
   logic        StallD;
   logic        FlushD;
   logic        PCSrcE;
   logic [31:0] PCTargetE;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic [31:0] imem_rdata;
   logic        imem_rvalid;
   logic [31:0] InstrD;
   logic [31:0] PCD;
   logic [31:0] PCPlus4D;
   logic        ValidD;

   int          n_tests = 0;
   int          n_fail  = 0;
   int          mem_lat = 1;
   exp_t        exp_q[$];
   logic [31:0] exp_req_q[$];

   instruction_fetch_stage #(
      .RESET_PC  (32'h0000_0000),
      .NOP_INSTR (32'h0000_0013)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .StallF      (StallF),
      .StallD      (StallD),
      .FlushD      (FlushD),
      .PCSrcE      (PCSrcE),
      .PCTargetE   (PCTargetE),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_rdata  (imem_rdata),
      .imem_rvalid (imem_rvalid),
      .InstrD      (InstrD),
      .PCD         (PCD),
      .PCPlus4D    (PCPlus4D),
      .ValidD      (ValidD)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      case (a)
         32'h0000_0000: return 32'h0010_0093;
         32'h0000_0004: return 32'h0020_0113;
         32'h0000_0008: return 32'h0030_0193;
         32'h0000_000C: return 32'h0050_0093;
         32'h0000_0010: return 32'h0060_0213;
         32'h0000_0100: return 32'h00A0_0293;
         32'h0000_0104: return 32'h00B0_0313;
         32'hFFFF_FFFC: return 32'h0070_0393;
         default:       return 32'hBAD0_0000;
      endcase
   endfunction

   task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wait_valid(input string name);
      bit got = 1'b0;
      for (int i = 0; i < 16; i++) begin
         @(posedge clk);
         #1;
         if (ValidD === 1'b1) begin
            got = 1'b1;
            break;
         end
      end
      n_tests++;
      if (!got) begin
         n_fail++;
         $display("FAIL %s: ValidD got 0 expected 1 within 16 cycles", name);
      end
   endtask

   task automatic push_exp(input logic [31:0] pc, input logic [31:0] pc4);
      exp_t e;
      e.instr = mem_word(pc);
      e.pc    = pc;
      e.pc4   = pc4;
      exp_q.push_back(e);
   endtask

   // Memory model: samples requests away from the edge, answers mem_lat cycles later.
   initial begin
      logic        req_seen;
      logic [31:0] addr_seen;
      logic [31:0] ea;
      logic [31:0] pend_data;
      int          pend_cnt;
      pend_cnt    = 0;
      pend_data   = '0;
      imem_rvalid = 1'b0;
      imem_rdata  = '0;
      forever begin
         @(negedge clk);
         req_seen  = imem_req;
         addr_seen = imem_addr;
         @(posedge clk);
         #1;
         imem_rvalid = 1'b0;
         if (req_seen === 1'b1) begin
            n_tests++;
            if (exp_req_q.size() == 0) begin
               n_fail++;
               $display("FAIL imem_req: unexpected request addr %h, none expected", addr_seen);
            end else begin
               ea = exp_req_q.pop_front();
               if (addr_seen !== ea) begin
                  n_fail++;
                  $display("FAIL imem_addr: got %h expected %h", addr_seen, ea);
               end
            end
            pend_cnt  = mem_lat;
            pend_data = mem_word(addr_seen);
         end
         if (pend_cnt > 0) begin
            pend_cnt--;
            if (pend_cnt == 0) begin
               imem_rvalid = 1'b1;
               imem_rdata  = pend_data;
            end
         end
      end
   end

   // Monitor: every freshly loaded valid IF/ID entry must match the head of the scoreboard.
   initial begin
      logic stall_seen;
      exp_t e;
      forever begin
         @(posedge clk);
         stall_seen = StallD;
         @(negedge clk);
         if (rst_n === 1'b1 && ValidD === 1'b1 && stall_seen === 1'b0) begin
            n_tests++;
            if (exp_q.size() == 0) begin
               n_fail++;
               $display("FAIL delivery: unexpected InstrD=%h PCD=%h, none expected", InstrD, PCD);
            end else begin
               e = exp_q.pop_front();
               if (InstrD !== e.instr || PCD !== e.pc || PCPlus4D !== e.pc4) begin
                  n_fail++;
                  $display("FAIL delivery: got %h/%h/%h expected %h/%h/%h",
                           InstrD, PCD, PCPlus4D, e.instr, e.pc, e.pc4);
               end
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n     = 1'b0;
      StallF    = 1'b0;
      StallD    = 1'b0;
      FlushD    = 1'b0;
      PCSrcE    = 1'b0;
      PCTargetE = '0;
      tick(2);
      check32("reset imem_req",  {31'd0, imem_req}, 32'd0);
      check32("reset imem_addr", imem_addr, 32'h0);
      check32("reset InstrD",    InstrD,    32'h0000_0013);
      check32("reset PCD",       PCD,       32'h0);
      check32("reset PCPlus4D",  PCPlus4D,  32'h0);
      check32("reset ValidD",    {31'd0, ValidD}, 32'd0);

      // Sequential fetch with 1-cycle memory.
      exp_req_q.push_back(32'h0);
      exp_req_q.push_back(32'h4);
      exp_req_q.push_back(32'h8);
      push_exp(32'h0, 32'h4);
      push_exp(32'h4, 32'h8);
      push_exp(32'h8, 32'hC);
      rst_n = 1'b1;
      wait_valid("seq0");
      wait_valid("seq1");
      wait_valid("seq2");
      StallF = 1'b1;
      tick(1);

      // Return lands while decode is stalled: word parks in the hold buffer.
      exp_req_q.push_back(32'hC);
      StallD = 1'b1;
      StallF = 1'b0;
      tick(2);
      check32("hold imem_req", {31'd0, imem_req}, 32'd0);
      check32("hold ValidD",   {31'd0, ValidD},   32'd0);
      tick(2);
      check32("hold imem_req later", {31'd0, imem_req}, 32'd0);
      push_exp(32'hC, 32'h10);
      StallD = 1'b0;
      wait_valid("hold release");
      check32("hold release InstrD", InstrD,    32'h0050_0093);
      check32("hold next addr",      imem_addr, 32'h10);
      StallF = 1'b1;
      tick(1);

      // Redirect while waiting: in-flight word is squashed.
      exp_req_q.push_back(32'h10);
      mem_lat = 3;
      StallF  = 1'b0;
      tick(1);
      PCSrcE    = 1'b1;
      PCTargetE = 32'h100;
      tick(1);
      PCSrcE  = 1'b0;
      mem_lat = 1;
      exp_req_q.push_back(32'h100);
      push_exp(32'h100, 32'h104);
      tick(2);
      check32("redirect imem_req",  {31'd0, imem_req}, 32'd1);
      check32("redirect imem_addr", imem_addr, 32'h100);
      wait_valid("redirect target");
      StallF = 1'b1;

      // Flush overrides stall.
      StallD = 1'b1;
      tick(1);
      check32("stall holds ValidD", {31'd0, ValidD}, 32'd1);
      check32("stall holds InstrD", InstrD, 32'h00A0_0293);
      FlushD = 1'b1;
      tick(1);
      check32("flush InstrD",   InstrD,   32'h0000_0013);
      check32("flush PCD",      PCD,      32'h0);
      check32("flush PCPlus4D", PCPlus4D, 32'h0);
      check32("flush ValidD",   {31'd0, ValidD}, 32'd0);
      FlushD = 1'b0;
      StallD = 1'b0;
      tick(1);

      // Reset in the middle of an outstanding fetch; the late return must be ignored.
      exp_req_q.push_back(32'h104);
      mem_lat = 3;
      StallF  = 1'b0;
      tick(1);
      #2;
      rst_n = 1'b0;
      #1;
      check32("async rst imem_req",  {31'd0, imem_req}, 32'd0);
      check32("async rst imem_addr", imem_addr, 32'h0);
      check32("async rst InstrD",    InstrD,    32'h0000_0013);
      check32("async rst ValidD",    {31'd0, ValidD}, 32'd0);
      @(posedge clk);
      #1;
      rst_n   = 1'b1;
      mem_lat = 1;
      exp_req_q.push_back(32'h0);
      push_exp(32'h0, 32'h4);
      wait_valid("after reset");
      StallF = 1'b1;
      tick(1);

      // Redirect alignment and PC wrap-around.
      PCSrcE    = 1'b1;
      PCTargetE = 32'h102;
      tick(1);
      check32("align imem_addr", imem_addr, 32'h100);
      check32("align imem_req",  {31'd0, imem_req}, 32'd0);
      PCTargetE = 32'hFFFF_FFFC;
      tick(1);
      check32("top imem_addr", imem_addr, 32'hFFFF_FFFC);
      PCSrcE = 1'b0;
      exp_req_q.push_back(32'hFFFF_FFFC);
      push_exp(32'hFFFF_FFFC, 32'h0);
      StallF = 1'b0;
      wait_valid("wrap");
      check32("wrap PCPlus4D",  PCPlus4D,  32'h0);
      check32("wrap imem_addr", imem_addr, 32'h0);
      StallF = 1'b1;
      tick(1);

      // Redirect, flush and return in the same cycle.
      exp_req_q.push_back(32'h0);
      StallF = 1'b0;
      tick(1);
      PCSrcE    = 1'b1;
      PCTargetE = 32'h200;
      FlushD    = 1'b1;
      tick(1);
      PCSrcE = 1'b0;
      FlushD = 1'b0;
      StallF = 1'b1;
      check32("combo ValidD",    {31'd0, ValidD}, 32'd0);
      check32("combo InstrD",    InstrD,    32'h0000_0013);
      check32("combo imem_addr", imem_addr, 32'h200);
      tick(3);

      check32("requests outstanding",   exp_req_q.size(), 32'd0);
      check32("deliveries outstanding", exp_q.size(),     32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
